// File: rtl/xdma_clock_ctrl_pkg.sv
// Shared definitions for the XDMA core-clock run controller: opcodes, FSM state
// and the core-period helper used by the controller and its phase counter.
package xdma_clock_pkg;

    localparam logic [1:0] XDMA_CLK_OP_HALT = 2'd0;
    localparam logic [1:0] XDMA_CLK_OP_RUN  = 2'd1;
    localparam logic [1:0] XDMA_CLK_OP_STEP = 2'd2;

    typedef enum logic [1:0] {
        XDMA_CLK_IDLE = 2'd0,
        XDMA_CLK_RUN  = 2'd1,
        XDMA_CLK_STEP = 2'd2
    } xdma_clk_state_t;

    // Host cycles per core period; DIV_HALF==0 means the core runs undivided.
    function automatic int unsigned xdma_clk_period(input int unsigned div_half);
        return (div_half > 0) ? (2 * div_half) : 1;
    endfunction

endpackage

// File: rtl/xdma_clock_ctrl_if.sv
// Host command / status bundle of the core-clock run controller.
// master = host register path, slave = xdma_clock_ctrl.
interface xdma_clock_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             stall_req;
    logic             core_clock_enable;
    logic             step_done;
    logic             busy;
    logic [63:0]      core_cycles;

    modport master (
        output cmd_valid, cmd_op, cmd_count, stall_req,
        input  cmd_ready, core_clock_enable, step_done, busy, core_cycles
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, stall_req,
        output cmd_ready, core_clock_enable, step_done, busy, core_cycles
    );
endinterface

// File: rtl/xdma_clock_ctrl_phase.sv
// Core-period phase counter: ph runs 0..P-1 and boundary flags the last host
// cycle of each core period (every cycle when undivided).
module xdma_clock_phase
    import xdma_clock_pkg::*;
#(
    parameter int unsigned DIV_HALF = 0
) (
    input  logic clock,
    input  logic reset,
    output logic boundary
);
    localparam int unsigned P    = xdma_clk_period(DIV_HALF);
    localparam int unsigned PH_W = (P > 1) ? $clog2(P) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(P - 1);

    logic [PH_W-1:0] ph_q;
    logic [PH_W-1:0] ph_d;

    always_comb begin
        ph_d = (ph_q == PH_LAST) ? '0 : (ph_q + PH_W'(1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_d;
        end
    end

    assign boundary = (ph_q == PH_LAST);

endmodule

// File: rtl/xdma_clock_ctrl.sv
// Run/step/halt controller producing a period-aligned core_clock_enable.
// Define XDMA_CLOCK_CYCLE_CNT_EN to build the 64-bit core_cycles counter.
module xdma_clock_ctrl
    import xdma_clock_pkg::*;
#(
    parameter int unsigned DIV_HALF = 0,
    parameter int          CNT_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    xdma_clock_ctrl_if.slave   host_if
);
    xdma_clk_state_t  state_q, state_d, state_c;
    logic [CNT_W-1:0] rem_q, rem_d, rem_c, rem_dec;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             boundary;
    logic             cmd_ready;
    logic             hs;
    logic             zero_step;
    logic             want;

    xdma_clock_phase #(
        .DIV_HALF (DIV_HALF)
    ) u_phase (
        .clock    (clock),
        .reset    (reset),
        .boundary (boundary)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= XDMA_CLK_IDLE;
            rem_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    // Next state: the command is applied first, then the boundary update sees its result.
    always_comb begin
        state_c   = state_q;
        rem_c     = rem_q;
        zero_step = 1'b0;
        if (hs) begin
            case (host_if.cmd_op)
                XDMA_CLK_OP_HALT: begin
                    state_c = XDMA_CLK_IDLE;
                    rem_c   = '0;
                end
                XDMA_CLK_OP_RUN: begin
                    state_c = XDMA_CLK_RUN;
                end
                XDMA_CLK_OP_STEP: begin
                    if (host_if.cmd_count == '0) begin
                        zero_step = 1'b1;
                    end else begin
                        state_c = XDMA_CLK_STEP;
                        rem_c   = host_if.cmd_count;
                    end
                end
                default: begin
                end
            endcase
        end

        rem_dec = rem_c;
        want    = 1'b0;
        state_d = state_c;
        rem_d   = rem_c;
        en_d    = en_q;
        done_d  = zero_step;
        if (boundary) begin
            if (en_q && (state_c == XDMA_CLK_STEP)) begin
                rem_dec = rem_c - CNT_W'(1);
            end
            want = (state_c == XDMA_CLK_RUN) ||
                   ((state_c == XDMA_CLK_STEP) && (rem_dec != '0));
            if ((state_c == XDMA_CLK_STEP) && (rem_dec == '0)) begin
                state_d = XDMA_CLK_IDLE;
                done_d  = 1'b1;
            end
            rem_d = rem_dec;
            en_d  = want && !host_if.stall_req;
        end
    end

    // Outputs; a HALT is never blocked, even mid-step.
    always_comb begin
        cmd_ready = (state_q != XDMA_CLK_STEP) || (host_if.cmd_op == XDMA_CLK_OP_HALT);
        hs        = host_if.cmd_valid && cmd_ready;
    end

    assign host_if.cmd_ready         = cmd_ready;
    assign host_if.core_clock_enable = en_q;
    assign host_if.step_done         = done_q;
    assign host_if.busy              = (state_q != XDMA_CLK_IDLE);

`ifdef XDMA_CLOCK_CYCLE_CNT_EN
    logic [63:0] cyc_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
        end else if (boundary && en_q) begin
            cyc_q <= cyc_q + 64'd1;
        end
    end

    assign host_if.core_cycles = cyc_q;
`else
    assign host_if.core_cycles = '0;
`endif

endmodule

// File: tb/tb_xdma_clock_ctrl.sv
// Bench for xdma_clock_ctrl: an undivided instance driven from a vector table
// and a DIV_HALF=2 instance driven by hand-written multi-cycle sequences.
module tb_xdma_clock_ctrl;
    import xdma_clock_pkg::*;

    localparam int CNT_W = 32;

`ifdef XDMA_CLOCK_CYCLE_CNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic rst1  = 1'b1;
    logic rst4  = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    xdma_clock_ctrl_if #(.CNT_W(CNT_W)) if1 ();
    xdma_clock_ctrl_if #(.CNT_W(CNT_W)) if4 ();

    xdma_clock_ctrl #(.DIV_HALF(0), .CNT_W(CNT_W)) dut1 (
        .clock   (clock),
        .reset   (rst1),
        .host_if (if1.slave)
    );

    xdma_clock_ctrl #(.DIV_HALF(2), .CNT_W(CNT_W)) dut4 (
        .clock   (clock),
        .reset   (rst4),
        .host_if (if4.slave)
    );

    typedef struct packed {
        logic        v;
        logic [1:0]  op;
        logic [31:0] cnt;
        logic        stall;
        logic        ready;
        logic        en;
        logic        done;
        logic        busy;
    } vec_t;

    vec_t vt [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [1:0] op, input logic [31:0] cnt, input logic st);
        if1.cmd_valid = v;
        if1.cmd_op    = op;
        if1.cmd_count = cnt;
        if1.stall_req = st;
    endtask

    task automatic drive4(input logic v, input logic [1:0] op, input logic [31:0] cnt, input logic st);
        if4.cmd_valid = v;
        if4.cmd_op    = op;
        if4.cmd_count = cnt;
        if4.stall_req = st;
    endtask

    task automatic do_reset1();
        drive1(1'b0, 2'd0, 32'd0, 1'b0);
        rst1 = 1'b1;
        tick();
        tick();
        rst1 = 1'b0;
    endtask

    task automatic do_reset4();
        drive4(1'b0, 2'd0, 32'd0, 1'b0);
        rst4 = 1'b1;
        tick();
        tick();
        rst4 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt;
        int done_cnt;

        // v, op, cnt, stall | ready, en, done, busy (outputs after the edge)
        vt[0]  = '{1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 2'd1, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 2'd2, 32'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 2'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 2'd2, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b1, 2'd2, 32'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[11] = '{1'b0, 2'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[12] = '{1'b1, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[13] = '{1'b1, 2'd3, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[14] = '{1'b1, 2'd1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[15] = '{1'b1, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        drive1(1'b0, 2'd0, 32'd0, 1'b0);
        drive4(1'b0, 2'd0, 32'd0, 1'b0);

        // Reset values, undivided instance
        do_reset1();
        check("rst1 en",     if1.core_clock_enable, 0);
        check("rst1 done",   if1.step_done, 0);
        check("rst1 busy",   if1.busy, 0);
        check("rst1 ready",  if1.cmd_ready, 1);
        check("rst1 cycles", if1.core_cycles, 0);

        // Vector table, P=1
        for (int i = 0; i < 16; i++) begin
            drive1(vt[i].v, vt[i].op, vt[i].cnt, vt[i].stall);
            #1;
            check($sformatf("vec%0d ready", i), if1.cmd_ready, vt[i].ready);
            tick();
            check($sformatf("vec%0d en", i),   if1.core_clock_enable, vt[i].en);
            check($sformatf("vec%0d done", i), if1.step_done, vt[i].done);
            check($sformatf("vec%0d busy", i), if1.busy, vt[i].busy);
            $display("vec%0d v=%0d op=%0d cnt=%0d stall=%0d -> en=%0d done=%0d busy=%0d",
                     i, vt[i].v, vt[i].op, vt[i].cnt, vt[i].stall,
                     if1.core_clock_enable, if1.step_done, if1.busy);
        end
        drive1(1'b0, 2'd0, 32'd0, 1'b0);
        check("vec cycles", if1.core_cycles, CC_EN ? 64'd6 : 64'd0);

        // P=1: RUN in cycle 5, HALT in cycle 20 -> enable on cycles 6..20
        do_reset1();
        for (int c = 0; c < 30; c++) begin
            check($sformatf("p1run c%0d en", c), if1.core_clock_enable, (c >= 6 && c <= 20));
            if (c == 5)       drive1(1'b1, XDMA_CLK_OP_RUN, 32'd0, 1'b0);
            else if (c == 20) drive1(1'b1, XDMA_CLK_OP_HALT, 32'd0, 1'b0);
            else              drive1(1'b0, 2'd0, 32'd0, 1'b0);
            tick();
        end
        check("p1run cycles", if1.core_cycles, CC_EN ? 64'd15 : 64'd0);
        $display("p1 run/halt: cycles=%0d", if1.core_cycles);

        // P=4: STEP 3 issued at ph=1
        do_reset4();
        check("rst4 en",     if4.core_clock_enable, 0);
        check("rst4 busy",   if4.busy, 0);
        check("rst4 ready",  if4.cmd_ready, 1);
        en_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k <= 20; k++) begin
            check($sformatf("step3 k%0d en", k),   if4.core_clock_enable, (k >= 4 && k <= 15));
            check($sformatf("step3 k%0d done", k), if4.step_done, (k == 16));
            check($sformatf("step3 k%0d busy", k), if4.busy, (k >= 2 && k <= 15));
            if (if4.core_clock_enable === 1'b1) en_cnt++;
            if (if4.step_done === 1'b1) done_cnt++;
            if (k == 1) drive4(1'b1, XDMA_CLK_OP_STEP, 32'd3, 1'b0);
            else        drive4(1'b0, 2'd0, 32'd0, 1'b0);
            tick();
        end
        check("step3 en_cycles", en_cnt, 12);
        check("step3 done_pulses", done_cnt, 1);
        $display("p4 step3: en_cycles=%0d done_pulses=%0d", en_cnt, done_cnt);

        // P=4: STEP 10 with stall over periods 4..6
        do_reset4();
        en_cnt = 0;
        for (int k = 0; k <= 60; k++) begin
            check($sformatf("stall k%0d en", k), if4.core_clock_enable,
                  ((k >= 4 && k <= 15) || (k >= 28 && k <= 55)));
            check($sformatf("stall k%0d done", k), if4.step_done, (k == 56));
            if (if4.core_clock_enable === 1'b1) en_cnt++;
            drive4((k == 1), XDMA_CLK_OP_STEP, 32'd10, (k >= 15 && k <= 26));
            tick();
        end
        check("stall en_cycles", en_cnt, 40);
        check("stall cycles", if4.core_cycles, CC_EN ? 64'd10 : 64'd0);
        $display("p4 step10 stall: en_cycles=%0d cycles=%0d", en_cnt, if4.core_cycles);

        // P=4: STEP 0
        do_reset4();
        for (int k = 0; k <= 10; k++) begin
            drive4((k == 1), XDMA_CLK_OP_STEP, 32'd0, 1'b0);
            #1;
            check($sformatf("step0 k%0d ready", k), if4.cmd_ready, 1);
            check($sformatf("step0 k%0d en", k),    if4.core_clock_enable, 0);
            check($sformatf("step0 k%0d done", k),  if4.step_done, (k == 2));
            tick();
        end
        $display("p4 step0 done");

        // P=4: STEP 100, RUN refused, HALT at ph=1 finishes the period
        do_reset4();
        for (int k = 0; k <= 20; k++) begin
            if (k == 1)                 drive4(1'b1, XDMA_CLK_OP_STEP, 32'd100, 1'b0);
            else if (k == 6 || k == 7)  drive4(1'b1, XDMA_CLK_OP_RUN, 32'd0, 1'b0);
            else if (k == 9)            drive4(1'b1, XDMA_CLK_OP_HALT, 32'd0, 1'b0);
            else                        drive4(1'b0, 2'd0, 32'd0, 1'b0);
            #1;
            if (k == 6 || k == 7) check($sformatf("halt k%0d run_ready", k), if4.cmd_ready, 0);
            if (k == 9)           check("halt k9 halt_ready", if4.cmd_ready, 1);
            check($sformatf("halt k%0d en", k),   if4.core_clock_enable, (k >= 4 && k <= 11));
            check($sformatf("halt k%0d done", k), if4.step_done, 0);
            check($sformatf("halt k%0d busy", k), if4.busy, (k >= 2 && k <= 9));
            tick();
        end
        $display("p4 step100 halt done");

        // P=4: asynchronous reset mid-RUN at ph=1
        do_reset4();
        for (int k = 0; k <= 8; k++) begin
            drive4((k == 1), XDMA_CLK_OP_RUN, 32'd0, 1'b0);
            tick();
        end
        check("areset pre en", if4.core_clock_enable, 1);
        rst4 = 1'b1;
        #1;
        check("areset en_now", if4.core_clock_enable, 0);
        check("areset busy_now", if4.busy, 0);
        tick();
        rst4 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("areset post k%0d en", k), if4.core_clock_enable, 0);
            check($sformatf("areset post k%0d busy", k), if4.busy, 0);
            tick();
        end
        $display("p4 async reset done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xdma_clock_ctrl.md
# xdma_clock_ctrl

Host-side run controller that produces the `core_clock_enable` consumed by the FPGA core-clock gate. It accepts run/step/halt commands from the XDMA host register path and honours backpressure from the difftest transmit buffer. It changes the enable only on core-clock period boundaries, so the gated core clock never emits a partial period. It sits in the host `clock` domain, directly upstream of the core-clock divider and gate.

## Interface
- `DIV_HALF`, default 0: host cycles per core half-period; 0 means undivided. Must match the divider setting.
- `CNT_W`, default 32: width of the step count.
- `clock` in 1: host clock; the only clock.
- `reset` in 1: asynchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid && cmd_ready`.
- `cmd_op` in 2: command opcode; 0 HALT, 1 RUN, 2 STEP, 3 reserved (accepted, ignored).
- `cmd_count` in `CNT_W`: core cycles for STEP.
- `stall_req` in 1: transmit-buffer backpressure; pause the core.
- `core_clock_enable` out 1: registered enable to the clock gate.
- `step_done` out 1: one-cycle pulse when a STEP completes.
- `busy` out 1: state is RUN or STEP.
- `core_cycles` out 64: enabled core periods since reset.

## Operation
- Period `P` is `2*DIV_HALF` if `DIV_HALF>0`, else 1.
- Phase counter `ph` counts 0..P-1 and wraps. It starts at 0 on reset release.
- A boundary is a cycle with `ph==P-1`.
- States:
  - IDLE: reset state.
  - RUN.
  - STEP: holds a `remaining` counter of width `CNT_W`.
- Transitions, at command handshake:
  - HALT: go to IDLE; `remaining` cleared.
  - RUN: go to RUN.
  - STEP with `cmd_count==0`: stay in current state; `step_done` pulses the next cycle.
  - STEP with `cmd_count>0`: go to STEP; `remaining` loaded with `cmd_count`.
- `cmd_ready` = state != STEP. A HALT is also accepted in STEP (`cmd_ready` high whenever `cmd_op==0`).
- At each boundary, `core_clock_enable` is updated to `want && !stall_req`, where `want` = (RUN) or (STEP and `remaining>0` after this boundary's decrement).
- Between boundaries the enable holds its value.
- An enabled period is a period that ends at a boundary with `core_clock_enable==1`. For each enabled period:
  - if in STEP, `remaining` decrements;
  - `core_cycles` increments.
- When `remaining` reaches 0 at a boundary:
  - `core_clock_enable` drops at that same boundary;
  - `step_done` pulses for the cycle after the boundary;
  - state goes to IDLE.
- A command that changes state takes effect on the enable only at the next boundary. A HALT mid-period therefore lets the current period finish.
- `stall_req` is sampled only at boundaries. Stalled periods do not decrement `remaining` or count cycles. STEP resumes with `remaining` preserved.
- A handshake in the same cycle as a boundary is applied before the enable update at that boundary.

## Timing
- Reset values:
  - `core_clock_enable`=0, `step_done`=0, `busy`=0, `cmd_ready`=1, `core_cycles`=0;
  - `ph`=0, state IDLE.
- Assertion of `reset` mid-operation drops the enable immediately (asynchronous).
- Enable latency: RUN accepted at cycle t raises the enable at the first boundary at or after t+1.
  - With P=1: enable high at t+1.
- `step_done` latency: 1 cycle after the final boundary.
- `core_cycles` wraps modulo 2^64.

## Configuration
- `XDMA_CLOCK_CYCLE_CNT_EN` defined: the 64-bit `core_cycles` counter is instantiated.
- Not defined: `core_cycles` is tied to 0 and no counter flops exist; all other behaviour is unchanged.

## Structure
- Shared package `xdma_clock_pkg`:
  - opcode constants `XDMA_CLK_OP_HALT`/`RUN`/`STEP`;
  - state enum `xdma_clk_state_t`;
  - helper function for period `P` from `DIV_HALF`.
- One sub-module `xdma_clock_phase`: the phase counter, with output `boundary`.

## Test plan
- P=1, RUN at cycle 5, HALT at cycle 20 -> enable high on cycles 6..20, low from 21; `core_cycles`=15.
- `DIV_HALF`=2 (P=4), STEP 3 -> enable high for exactly 12 host cycles, aligned to `ph==3` boundaries; `step_done` pulses once; state returns to IDLE.
- STEP 10 with `stall_req` held high for periods 4..6 -> 10 enabled periods total, enable low during the stall, `step_done` after 13 periods.
- STEP 0 -> `step_done` next cycle, enable never rises, `cmd_ready` stays 1.
- During STEP 100, a RUN is presented -> `cmd_ready`=0 and the RUN is not accepted; a HALT is accepted and drops the enable at the next boundary with no `step_done`.
- `reset` asserted mid-RUN with P=4 at `ph`=1 -> enable 0 immediately; after release, enable stays 0 until a new command.
